// File: rtl/aes_cbc_dec_chain.sv
// CBC chaining wrapper downstream of an AES decipher core: one block in flight.
// Optional ECB bypass via `define AES_CBC_DEC_ECB_MODE_EN (adds the ecb_mode port).
module aes_cbc_dec_chain #(
  parameter int CTR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 iv_load,
  input  logic [127:0]         iv,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_block,
  output logic                 dec_next,
  output logic [127:0]         dec_block,
  input  logic                 dec_ready,
  input  logic [127:0]         dec_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_block,
`ifdef AES_CBC_DEC_ECB_MODE_EN
  input  logic                 ecb_mode,
`endif
  output logic [CTR_WIDTH-1:0] block_count
);

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  state_t               state, state_nxt;
  logic [127:0]         iv_reg, ct_reg, out_reg;
  logic [CTR_WIDTH-1:0] cnt;
  logic                 mode_reg, mode_in;
  logic                 ld_iv, cap, done;

`ifdef AES_CBC_DEC_ECB_MODE_EN
  assign mode_in = ecb_mode;
`else
  assign mode_in = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    dec_next  = 1'b0;
    out_valid = 1'b0;
    ld_iv     = 1'b0;
    cap       = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        ld_iv    = iv_load;
        if (in_valid) begin
          cap       = 1'b1;
          state_nxt = START;
        end
      end
      // Decipher still reports ready while sampling next, so skip dec_ready here.
      START: begin
        dec_next  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (dec_ready) begin
        done      = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ld_iv (IDLE) and done (WAIT) never coincide, so the shared writes are ordered safely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iv_reg   <= '0;
      ct_reg   <= '0;
      out_reg  <= '0;
      cnt      <= '0;
      mode_reg <= 1'b0;
    end else begin
      if (ld_iv) begin
        iv_reg <= iv;
        cnt    <= '0;
      end
      if (cap) begin
        ct_reg   <= in_block;
        mode_reg <= mode_in;
      end
      if (done) begin
        out_reg <= mode_reg ? dec_result : (dec_result ^ iv_reg);
        if (!mode_reg) iv_reg <= ct_reg;
        cnt <= cnt + CTR_WIDTH'(1);
      end
    end
  end

  assign dec_block   = ct_reg;
  assign out_block   = out_reg;
  assign block_count = cnt;

endmodule

// File: tb/tb_aes_cbc_dec_chain.sv
// Self-checking bench: decipher stub plus a block-level CBC reference model.
module tb_aes_cbc_dec_chain;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         iv_load = 1'b0;
  logic [127:0] iv = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_block = '0;
  logic         dec_next;
  logic [127:0] dec_block;
  logic         dec_ready;
  logic [127:0] dec_result;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_block;
  logic [31:0]  block_count;
`ifdef AES_CBC_DEC_ECB_MODE_EN
  logic         ecb_mode = 1'b0;
`endif

  aes_cbc_dec_chain #(.CTR_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .iv_load(iv_load), .iv(iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .dec_next(dec_next), .dec_block(dec_block), .dec_ready(dec_ready),
    .dec_result(dec_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block),
`ifdef AES_CBC_DEC_ECB_MODE_EN
    .ecb_mode(ecb_mode),
`endif
    .block_count(block_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // AES-128 decrypt results for the two NIST CBC ciphertexts; pseudo-decrypt otherwise.
  function automatic logic [127:0] dec_f(input logic [127:0] x);
    if (x == 128'h7649abac8119b246cee98e9b12e9197d) return 128'h6bc0bce12a459991e134741a7f9e1925;
    if (x == 128'h5086cb9b507219ee95db113a917678b2) return 128'hd86421fb9f1a1eda505ee1375746972c;
    return {x[63:0], x[127:64]} ^ 128'hc3c3_1234_5678_9abc_def0_0f1e_2d3c_4b5a;
  endfunction

  // Decipher stub: busy for lat_m cycles after sampling next, ready otherwise.
  int           lat_m = 5;
  bit           force_en = 1'b0;
  logic [127:0] force_val = '0;
  int           scnt = 0;
  logic [127:0] sres = '0;
  always @(posedge clk) begin
    if (dec_next) begin
      scnt <= lat_m;
      sres <= force_en ? force_val : dec_f(dec_block);
    end else if (scnt != 0) scnt <= scnt - 1;
  end
  assign dec_ready  = (scnt == 0);
  assign dec_result = sres;

  int nxt_tot = 0;
  always @(posedge clk) if (dec_next) nxt_tot <= nxt_tot + 1;

  // Reference model state
  logic [127:0] iv_m = '0;
  logic [31:0]  cnt_m = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_block(input logic [127:0] ct, input bit ld, input logic [127:0] niv,
                           input bit ecb, input int hold, input bit poke,
                           output logic [127:0] got);
    int n;
    int nbase;
    bit e;
    logic [127:0] dv, exp, held;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("in_ready_idle", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1; in_block = ct; iv_load = ld; iv = niv;
`ifdef AES_CBC_DEC_ECB_MODE_EN
    ecb_mode = ecb;
    e = ecb;
`else
    e = 1'b0;
    if (ecb) e = 1'b0;
`endif
    nbase = nxt_tot;
    @(negedge clk);
    in_valid = 1'b0; iv_load = 1'b0;
    if (ld) begin iv_m = niv; cnt_m = '0; end
    dv = force_en ? force_val : dec_f(ct);
    if (e) exp = dv;
    else begin exp = dv ^ iv_m; iv_m = ct; end
    cnt_m = cnt_m + 1;
    chk("dec_next_start", {127'd0, dec_next}, 128'd1);
    n = 1;
    while (!out_valid && n < 300) begin
      @(negedge clk); n++;
      iv_load  = poke && (n == 3);
      in_valid = poke && (n == 3);
      iv       = ~iv_m;
    end
    iv_load = 1'b0; in_valid = 1'b0;
    chk("latency", 128'(n), 128'(3 + lat_m));
    chk("out_block", out_block, exp);
    chk("block_count", {96'd0, block_count}, {96'd0, cnt_m});
    chk("dec_next_once", 128'(nxt_tot - nbase), 128'd1);
    chk("dec_block", dec_block, ct);
    held = out_block;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = poke && i[0];
      in_block = {4{$urandom}};
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
      chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_stable", out_block, held);
    end
    in_valid = 1'b0;
    if (hold > 0) chk("bp_no_next", 128'(nxt_tot - nbase), 128'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_drop", {127'd0, out_valid}, 128'd0);
    chk("back_idle", {127'd0, in_ready}, 128'd1);
    got = held;
  endtask

  initial begin
    logic [127:0] got, ivx;
    // Reset defaults
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_dec_next", {127'd0, dec_next}, 128'd0);
    chk("rst_count", {96'd0, block_count}, 128'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset while waiting on the decipher, then a stale ready
    lat_m = 10;
    in_valid = 1'b1; in_block = 128'h1111; iv_load = 1'b1; iv = 128'h22;
    @(negedge clk);
    in_valid = 1'b0; iv_load = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("arst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("arst_dec_next", {127'd0, dec_next}, 128'd0);
    chk("arst_count", {96'd0, block_count}, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    iv_m = '0; cnt_m = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i % 5 == 4) chk("stale_ready", {127'd0, out_valid}, 128'd0);
    end

    // NIST CBC vectors, second one under backpressure with in_valid pokes
    lat_m = 5;
    run_block(128'h7649abac8119b246cee98e9b12e9197d, 1'b1, 128'h000102030405060708090a0b0c0d0e0f,
              1'b0, 0, 1'b0, got);
    chk("nist_blk1", got, 128'h6bc1bee22e409f96e93d7e117393172a);
    run_block(128'h5086cb9b507219ee95db113a917678b2, 1'b0, '0, 1'b0, 20, 1'b1, got);
    chk("nist_blk2", got, 128'hae2d8a571e03ac9c9eb76fac45af8e51);
    chk("nist_count", {96'd0, block_count}, 128'd2);

    // Stub returning all ones: IV load with the block, then IV load in WAIT ignored
    force_en = 1'b1; force_val = '1;
    ivx = 128'h0123456789abcdef0123456789abcdef;
    run_block({4{$urandom}}, 1'b1, ivx, 1'b0, 0, 1'b1, got);
    chk("iv_with_block", got, ~ivx);
    chk("count_restart", {96'd0, block_count}, 128'd1);
    run_block({4{$urandom}}, 1'b0, '0, 1'b0, 2, 1'b1, got);

`ifdef AES_CBC_DEC_ECB_MODE_EN
    force_val = {16{8'ha5}};
    run_block({4{$urandom}}, 1'b0, '0, 1'b1, 0, 1'b0, got);
    chk("ecb_passthru", got, {16{8'ha5}});
    force_en = 1'b0;
    run_block({4{$urandom}}, 1'b0, '0, 1'b0, 0, 1'b0, got);
`endif

    // Randomized traffic
    force_en = 1'b0;
    for (int k = 0; k < 24; k++) begin
      lat_m = int'($urandom_range(2, 8));
      run_block({$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 3) == 0),
                {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/aes_cbc_dec_chain.md
Name: aes_cbc_dec_chain

Overview:
- Cipher-block-chaining wrapper placed directly downstream of the AES decipher block.
- Accepts ciphertext blocks over a valid/ready handshake and launches the decipher with a one-cycle next pulse.
- Waits for the decipher to signal ready, then XORs the decipher result with the chaining value to produce plaintext.
- Presents the plaintext on a valid/ready output port and advances the chaining value to the consumed ciphertext.

Parameters:
- CTR_WIDTH, 32, width of the completed-block counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- iv_load  in  1  load iv into the chaining register; honoured only while in_ready=1
- iv  in  128  initialisation vector
- in_valid  in  1  ciphertext block valid
- in_ready  out  1  block can accept ciphertext (high only in IDLE)
- in_block  in  128  ciphertext block
- dec_next  out  1  one-cycle start pulse to the decipher
- dec_block  out  128  ciphertext to the decipher; equals ct_reg
- dec_ready  in  1  decipher ready/done
- dec_result  in  128  decipher output block
- out_valid  out  1  plaintext valid
- out_ready  in  1  downstream accepts plaintext
- out_block  out  128  plaintext
- block_count  out  CTR_WIDTH  completed blocks since reset or last IV load

Behaviour:
- Clock and reset:
  - Single clock clk; reset_n is asynchronous, active-low.
  - All registers update on the rising edge with write enables.
- Reset values:
  - State IDLE.
  - iv_reg, ct_reg, out_reg = 0; block_count = 0.
  - in_ready = 1; dec_next = 0; out_valid = 0.
- FSM states: IDLE, START, WAIT, OUT.
- IDLE:
  - in_ready = 1.
  - If iv_load = 1: iv_reg <= iv and block_count <= 0.
  - If in_valid = 1: ct_reg <= in_block, go to START.
  - If iv_load and in_valid are both high in the same cycle, the IV loads first and the captured block uses the new IV. The chaining XOR happens later and reads iv_reg.
- START:
  - dec_next = 1 for exactly this one cycle; go to WAIT.
  - dec_ready is ignored in START, because the decipher still shows ready=1 in the cycle it samples next.
- WAIT:
  - dec_next = 0.
  - When dec_ready = 1: out_reg <= dec_result ^ iv_reg, iv_reg <= ct_reg, block_count <= block_count + 1 (wraps modulo 2^CTR_WIDTH), go to OUT.
  - No timeout; the block stays in WAIT indefinitely.
- OUT:
  - out_valid = 1; out_block = out_reg, held stable until accepted.
  - When out_ready = 1: go to IDLE (out_valid drops the next cycle).
- Timing and sequencing:
  - dec_block = ct_reg, stable from START until the next accepted block.
  - Latency from in_valid & in_ready to out_valid = 3 + decipher busy cycles.
  - No pipelining: one block in flight; next acceptance is at the earliest the cycle after the out handshake.
- Ignored inputs:
  - iv_load outside IDLE is ignored, with no effect on iv_reg or block_count.
  - in_valid outside IDLE is ignored; the upstream must hold the block until in_ready.
- Reset mid-operation: immediate return to reset values. A decipher already started is not aborted by this block; its later ready is ignored because state is IDLE.

Optional Feature:
- Macro: AES_CBC_DEC_ECB_MODE_EN.
- When defined:
  - Adds input port ecb_mode (1 bit), sampled at in-handshake and stored alongside ct_reg.
  - If stored mode = 1: out_reg <= dec_result (no XOR), iv_reg unchanged; block_count still increments.
- When undefined: the port is absent and behaviour is always CBC as above.

Test Plan:
- Reset defaults: assert reset_n=0 mid-WAIT -> in_ready=1, out_valid=0, dec_next=0, block_count=0 asynchronously. After release, a stale dec_ready=1 produces no output.
- Single CBC block: real decipher, AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102030405060708090a0b0c0d0e0f, in_block 7649abac8119b246cee98e9b12e9197d -> out_block 6bc1bee22e409f96e93d7e117393172a, dec_next exactly one cycle, block_count=1.
- Chaining: follow with 5086cb9b507219ee95db113a917678b2 without reloading IV -> ae2d8a571e03ac9c9eb76fac45af8e51, block_count=2.
- Backpressure: hold out_ready=0 for 20 cycles and pulse in_valid meanwhile -> out_block stable, in_ready=0, no second dec_next. Then out_ready=1 -> IDLE the next cycle.
- IV and stub checks, with a decipher stub returning ffff...ff after 5 cycles:
  - iv_load together with in_valid, iv=0123...ef -> out_block = ~iv, block_count restarts at 1.
  - iv_load while in WAIT -> ignored.
- Optional feature: with AES_CBC_DEC_ECB_MODE_EN and ecb_mode=1, the stub result a5a5...a5 -> out_block a5a5...a5 and iv_reg unchanged. A following CBC block uses the old IV.
